// File: rtl/count_seq_monitor_if.sv
// Signal bundle between the upstream 3-bit counter side and count_seq_monitor.
// Optional capture outputs exist only when COUNT_SEQ_MON_CAPTURE_EN is defined.
interface count_seq_monitor_if #(
  parameter int CW = 3,
  parameter int WW = 8
);
  logic [CW-1:0] count_in;
  logic          count_valid;
  logic          up_reset;
  logic          clr;
  logic          wrap_pulse;
  logic [WW-1:0] wrap_count;
  logic          skip_err;
  logic          stall_err;
  logic          tracking;
`ifdef COUNT_SEQ_MON_CAPTURE_EN
  logic [CW-1:0] cap_exp;
  logic [CW-1:0] cap_obs;
`endif

  modport master (
    output count_in, count_valid, up_reset, clr,
`ifdef COUNT_SEQ_MON_CAPTURE_EN
    input  cap_exp, cap_obs,
`endif
    input  wrap_pulse, wrap_count, skip_err, stall_err, tracking
  );

  modport slave (
    input  count_in, count_valid, up_reset, clr,
`ifdef COUNT_SEQ_MON_CAPTURE_EN
    output cap_exp, cap_obs,
`endif
    output wrap_pulse, wrap_count, skip_err, stall_err, tracking
  );
endinterface

// File: rtl/count_seq_monitor.sv
// Sequence checker for a free-running up counter: wrap counting, skip and stall detection.
// Optional mismatch capture (cap_exp/cap_obs) enabled by COUNT_SEQ_MON_CAPTURE_EN.
//
// state    | meaning
// ST_INIT  | waiting for first valid sample, no checks
// ST_TRACK | checking each valid sample against prev+1
// ST_FAULT | flag raised; flags and wrap_count frozen until clr/reset
module count_seq_monitor #(
  parameter int CW        = 3,
  parameter int WW        = 8,
  parameter int STALL_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  count_seq_monitor_if.slave mon
);

  typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [WW-1:0] WRAP_MAX = {WW{1'b1}};
  localparam logic [8:0]    STALL_LIM = 9'(STALL_MAX);

  state_t        state, state_nxt;
  logic [CW-1:0] prev, prev_nxt;
  logic [7:0]    stall_cnt, stall_nxt;
  logic [8:0]    stall_inc;
  logic [CW-1:0] exp_val;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic          pulse_q, pulse_nxt;
  logic          skip_q, skip_nxt;
  logic          serr_q, serr_nxt;
  logic          trk_q, trk_nxt;
`ifdef COUNT_SEQ_MON_CAPTURE_EN
  logic [CW-1:0] cap_exp_q, cap_exp_nxt;
  logic [CW-1:0] cap_obs_q, cap_obs_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      prev      <= '0;
      stall_cnt <= '0;
      wcnt      <= '0;
      pulse_q   <= 1'b0;
      skip_q    <= 1'b0;
      serr_q    <= 1'b0;
      trk_q     <= 1'b0;
`ifdef COUNT_SEQ_MON_CAPTURE_EN
      cap_exp_q <= '0;
      cap_obs_q <= '0;
`endif
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      stall_cnt <= stall_nxt;
      wcnt      <= wcnt_nxt;
      pulse_q   <= pulse_nxt;
      skip_q    <= skip_nxt;
      serr_q    <= serr_nxt;
      trk_q     <= trk_nxt;
`ifdef COUNT_SEQ_MON_CAPTURE_EN
      cap_exp_q <= cap_exp_nxt;
      cap_obs_q <= cap_obs_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    stall_nxt = stall_cnt;
    wcnt_nxt  = wcnt;
    pulse_nxt = 1'b0;
    skip_nxt  = skip_q;
    serr_nxt  = serr_q;
`ifdef COUNT_SEQ_MON_CAPTURE_EN
    cap_exp_nxt = cap_exp_q;
    cap_obs_nxt = cap_obs_q;
`endif
    exp_val   = prev + CW'(1);
    stall_inc = {1'b0, stall_cnt} + 9'd1;

    // clr wins over a coincident sample; prev/stall_cnt are reloaded in INIT anyway
    if (mon.clr) begin
      state_nxt = ST_INIT;
      wcnt_nxt  = '0;
      skip_nxt  = 1'b0;
      serr_nxt  = 1'b0;
`ifdef COUNT_SEQ_MON_CAPTURE_EN
      cap_exp_nxt = '0;
      cap_obs_nxt = '0;
`endif
    end else if (mon.count_valid) begin
      prev_nxt = mon.count_in;
      unique case (state)
        ST_INIT: begin
          stall_nxt = 8'd1;
          state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          if (mon.count_in == exp_val) begin
            stall_nxt = 8'd1;
            if (prev == CNT_MAX) begin
              pulse_nxt = 1'b1;
              if (wcnt != WRAP_MAX) wcnt_nxt = wcnt + WW'(1);
            end
          end else if (mon.count_in == prev) begin
            if (stall_inc >= STALL_LIM) begin
              stall_nxt = STALL_LIM[7:0];
              serr_nxt  = 1'b1;
              state_nxt = ST_FAULT;
            end else begin
              stall_nxt = stall_inc[7:0];
            end
          end else if (mon.count_in == '0 && mon.up_reset) begin
            stall_nxt = 8'd1;
          end else begin
            skip_nxt  = 1'b1;
            state_nxt = ST_FAULT;
`ifdef COUNT_SEQ_MON_CAPTURE_EN
            cap_exp_nxt = exp_val;
            cap_obs_nxt = mon.count_in;
`endif
          end
        end
        ST_FAULT: ;
        default: state_nxt = ST_INIT;
      endcase
    end

    trk_nxt = (state_nxt == ST_TRACK);
  end

  assign mon.wrap_pulse = pulse_q;
  assign mon.wrap_count = wcnt;
  assign mon.skip_err   = skip_q;
  assign mon.stall_err  = serr_q;
  assign mon.tracking   = trk_q;
`ifdef COUNT_SEQ_MON_CAPTURE_EN
  assign mon.cap_exp    = cap_exp_q;
  assign mon.cap_obs    = cap_obs_q;
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// Scoreboard bench for count_seq_monitor: a WW=8 and a WW=2 instance share the same stimulus.
module tb_count_seq_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  count_seq_monitor_if #(.CW(3), .WW(8)) if8 ();
  count_seq_monitor_if #(.CW(3), .WW(2)) if2 ();

  assign if2.count_in    = if8.count_in;
  assign if2.count_valid = if8.count_valid;
  assign if2.up_reset    = if8.up_reset;
  assign if2.clr         = if8.clr;

  count_seq_monitor #(.CW(3), .WW(8), .STALL_MAX(4)) dut8 (.clk(clk), .reset(reset), .mon(if8));
  count_seq_monitor #(.CW(3), .WW(2), .STALL_MAX(4)) dut2 (.clk(clk), .reset(reset), .mon(if2));

  typedef struct {
    int st;   // 0 init, 1 track, 2 fault
    int prev;
    int stall;
    int wc;
    bit pulse;
    bit skip;
    bit serr;
    int ce;
    int co;
  } mdl_t;

  mdl_t m8, m2, e8, e2;
  mdl_t q8[$];
  mdl_t q2[$];
  int n_cmp = 0;
  int n_bad = 0;
  int p8, p2;

  function automatic mdl_t mstep(mdl_t m, bit v, int c, bit u, bit cl, int wmax);
    mdl_t n;
    int e;
    n = m;
    n.pulse = 0;
    e = (m.prev + 1) % 8;
    if (cl) begin
      n.st = 0; n.wc = 0; n.skip = 0; n.serr = 0; n.ce = 0; n.co = 0;
    end else if (v) begin
      n.prev = c;
      if (m.st == 0) begin
        n.stall = 1; n.st = 1;
      end else if (m.st == 1) begin
        if (c == e) begin
          n.stall = 1;
          if (m.prev == 7) begin
            n.pulse = 1;
            if (m.wc < wmax) n.wc = m.wc + 1;
          end
        end else if (c == m.prev) begin
          n.stall = m.stall + 1;
          if (n.stall >= 4) begin
            n.stall = 4; n.serr = 1; n.st = 2;
          end
        end else if (c == 0 && u) begin
          n.stall = 1;
        end else begin
          n.skip = 1; n.st = 2; n.ce = e; n.co = c;
        end
      end
    end
    return n;
  endfunction

  // scoreboard: every pushed expectation is checked 1 time unit after its edge
  always @(posedge clk) begin
    if (q8.size() > 0) begin
      #1;
      e8 = q8.pop_front();
      e2 = q2.pop_front();
      n_cmp++;
      if ({if8.wrap_pulse, if8.wrap_count, if8.skip_err, if8.stall_err, if8.tracking} !==
          {e8.pulse, 8'(e8.wc), e8.skip, e8.serr, (e8.st == 1)}) begin
        n_bad++;
        $display("FAIL sb_w8 t=%0t act pulse=%0b wc=%0d skip=%0b stall=%0b trk=%0b exp pulse=%0b wc=%0d skip=%0b stall=%0b trk=%0b",
                 $time, if8.wrap_pulse, if8.wrap_count, if8.skip_err, if8.stall_err, if8.tracking,
                 e8.pulse, e8.wc, e8.skip, e8.serr, (e8.st == 1));
      end
      n_cmp++;
      if ({if2.wrap_pulse, if2.wrap_count, if2.skip_err, if2.stall_err, if2.tracking} !==
          {e2.pulse, 2'(e2.wc), e2.skip, e2.serr, (e2.st == 1)}) begin
        n_bad++;
        $display("FAIL sb_w2 t=%0t act pulse=%0b wc=%0d skip=%0b stall=%0b trk=%0b exp pulse=%0b wc=%0d skip=%0b stall=%0b trk=%0b",
                 $time, if2.wrap_pulse, if2.wrap_count, if2.skip_err, if2.stall_err, if2.tracking,
                 e2.pulse, e2.wc, e2.skip, e2.serr, (e2.st == 1));
      end
`ifdef COUNT_SEQ_MON_CAPTURE_EN
      n_cmp++;
      if ({if8.cap_exp, if8.cap_obs} !== {3'(e8.ce), 3'(e8.co)}) begin
        n_bad++;
        $display("FAIL sb_cap t=%0t act exp=%0d obs=%0d want exp=%0d obs=%0d",
                 $time, if8.cap_exp, if8.cap_obs, e8.ce, e8.co);
      end
`endif
    end
  end

  task automatic step(input bit v, input int c, input bit u = 1'b0, input bit cl = 1'b0);
    @(negedge clk);
    if8.count_valid = v;
    if8.count_in    = v ? 3'(c) : 3'($urandom_range(0, 7));
    if8.up_reset    = u;
    if8.clr         = cl;
    m8 = mstep(m8, v, c, u, cl, 255);
    m2 = mstep(m2, v, c, u, cl, 3);
    q8.push_back(m8);
    q2.push_back(m2);
    @(posedge clk);
    #2;
    if (if8.wrap_pulse) p8++;
    if (if2.wrap_pulse) p2++;
    if8.count_valid = 1'b0;
    if8.clr         = 1'b0;
    if8.up_reset    = 1'b0;
  endtask

  task automatic test_reset();
    if8.count_valid = 1'b0;
    if8.count_in    = 3'd5;
    if8.up_reset    = 1'b0;
    if8.clr         = 1'b0;
    m8 = '{default: 0};
    m2 = '{default: 0};
    #13;
    n_cmp++;
    if ({if8.wrap_pulse, if8.wrap_count, if8.skip_err, if8.stall_err, if8.tracking} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_out act=%0h want 0", {if8.wrap_pulse, if8.wrap_count, if8.skip_err, if8.stall_err, if8.tracking});
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    p8 = 0; p2 = 0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        step(1'b1, i);
        if (i == 3) step(1'b0, 0);
      end
    step(1'b1, 0);
    n_cmp++;
    if (p8 !== 2) begin n_bad++; $display("FAIL wrap_pulses act=%0d want 2", p8); end
    n_cmp++;
    if (if8.wrap_count !== 8'd2 || if8.tracking !== 1'b1 || if8.skip_err !== 1'b0 || if8.stall_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_final act wc=%0d trk=%0b skip=%0b stall=%0b want 2 1 0 0",
               if8.wrap_count, if8.tracking, if8.skip_err, if8.stall_err);
    end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_skip();
    step(1'b1, 3);
    step(1'b1, 4);
    step(1'b1, 6);
    n_cmp++;
    if (if8.skip_err !== 1'b1 || if8.tracking !== 1'b0) begin
      n_bad++;
      $display("FAIL skip_flag act skip=%0b trk=%0b want 1 0", if8.skip_err, if8.tracking);
    end
`ifdef COUNT_SEQ_MON_CAPTURE_EN
    n_cmp++;
    if (if8.cap_exp !== 3'd5 || if8.cap_obs !== 3'd6) begin
      n_bad++;
      $display("FAIL skip_cap act exp=%0d obs=%0d want 5 6", if8.cap_exp, if8.cap_obs);
    end
`endif
    step(1'b1, 7);
    step(1'b1, 0);
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) step(1'b1, 2);
    n_cmp++;
    if (if8.stall_err !== 1'b1) begin n_bad++; $display("FAIL stall_4 act=%0b want 1", if8.stall_err); end
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 2);
    step(1'b1, 2);
    step(1'b0, 0);
    step(1'b1, 2);
    step(1'b1, 3);
    n_cmp++;
    if (if8.stall_err !== 1'b0 || if8.tracking !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_3 act stall=%0b trk=%0b want 0 1", if8.stall_err, if8.tracking);
    end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_up_reset();
    p8 = 0;
    step(1'b1, 5);
    step(1'b1, 6);
    step(1'b1, 0, 1'b1);
    step(1'b1, 1);
    step(1'b1, 2);
    n_cmp++;
    if (if8.skip_err !== 1'b0 || if8.stall_err !== 1'b0 || p8 !== 0) begin
      n_bad++;
      $display("FAIL upr_legal act skip=%0b stall=%0b pulses=%0d want 0 0 0", if8.skip_err, if8.stall_err, p8);
    end
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 5);
    step(1'b1, 6);
    step(1'b1, 0, 1'b0);
    n_cmp++;
    if (if8.skip_err !== 1'b1) begin n_bad++; $display("FAIL upr_skip act=%0b want 1", if8.skip_err); end
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 3);
    step(1'b1, 5, 1'b1);
    n_cmp++;
    if (if8.skip_err !== 1'b1) begin n_bad++; $display("FAIL upr_nonzero act=%0b want 1", if8.skip_err); end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    p8 = 0; p2 = 0;
    step(1'b1, 0);
    for (int r = 0; r < 5; r++)
      for (int i = 1; i <= 8; i++) step(1'b1, i % 8);
    n_cmp++;
    if (p2 !== 5 || if2.wrap_count !== 2'd3) begin
      n_bad++;
      $display("FAIL sat_w2 act pulses=%0d wc=%0d want 5 3", p2, if2.wrap_count);
    end
    n_cmp++;
    if (if8.wrap_count !== 8'd5) begin n_bad++; $display("FAIL sat_w8 act=%0d want 5", if8.wrap_count); end
    step(1'b1, 1, 1'b0, 1'b1);
    n_cmp++;
    if (if2.wrap_count !== 2'd0 || if2.tracking !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_prio act wc=%0d trk=%0b want 0 0", if2.wrap_count, if2.tracking);
    end
    step(1'b1, 5);
    step(1'b1, 6);
    n_cmp++;
    if (if2.tracking !== 1'b1 || if2.skip_err !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_reinit act trk=%0b skip=%0b want 1 0", if2.tracking, if2.skip_err);
    end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    step(1'b1, 6);
    step(1'b1, 7);
    step(1'b1, 0);
    n_cmp++;
    if (if8.wrap_count !== 8'd1 || if8.wrap_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset act wc=%0d pulse=%0b want 1 1", if8.wrap_count, if8.wrap_pulse);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({if8.wrap_pulse, if8.wrap_count, if8.skip_err, if8.stall_err, if8.tracking} !== 13'd0) begin
      n_bad++;
      $display("FAIL async_reset act=%0h want 0", {if8.wrap_pulse, if8.wrap_count, if8.skip_err, if8.stall_err, if8.tracking});
    end
    m8 = '{default: 0};
    m2 = '{default: 0};
    #1;
    reset = 1'b0;
    step(1'b1, 6);
    step(1'b1, 7);
    n_cmp++;
    if (if8.tracking !== 1'b1 || if8.skip_err !== 1'b0 || if8.stall_err !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset act trk=%0b skip=%0b stall=%0b want 1 0 0", if8.tracking, if8.skip_err, if8.stall_err);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_skip();
    test_stall();
    test_up_reset();
    test_saturate();
    test_async_reset();
    repeat (2) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream checker for the free-running 3-bit synchronous up counter; samples its count output every valid cycle.
- Counts wrap events (max->0) and raises a one-cycle wrap strobe.
- Sets sticky flags when the count skips a value or stalls too long.
- Drives the debug/status register bank and the wrap-rate logic that consumes the counter.

Parameters:
- CW, 3, count width under observation; max value 2^CW-1.
- WW, 8, width of the wrap event counter.
- STALL_MAX, 4, consecutive valid samples with an unchanged count that trigger stall_err; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset of all state.
- count_in  input  CW  count value from the upstream counter.
- count_valid  input  1  count_in is meaningful this cycle; sample only when high.
- up_reset  input  1  mirror of the upstream counter's synchronous reset. A valid sample of 0 while this is high is legal.
- clr  input  1  synchronous clear of flags, wrap_count and FSM.
- wrap_pulse  output  1  one-cycle strobe on a detected wrap.
- wrap_count  output  WW  saturating count of wraps.
- skip_err  output  1  sticky; a sequence discontinuity was seen.
- stall_err  output  1  sticky; count unchanged for STALL_MAX valid samples.
- tracking  output  1  high while the FSM is in TRACK.

Behaviour:
- Reset (async, any time): FSM=INIT, prev=0, stall_cnt=0, all outputs 0. Deassertion takes effect on the next rising edge.
- All outputs are registered. A sample at edge N is reflected on outputs after edge N.
- FSM states: INIT, TRACK, FAULT.
- INIT:
  - On the first valid sample: store prev=count_in, stall_cnt=1, go to TRACK.
  - No checks are done on this sample.
- TRACK, on each valid sample, with exp = (prev+1) mod 2^CW:
  - count_in==exp: if prev==2^CW-1 (so count_in==0), pulse wrap_pulse and increment wrap_count. wrap_count saturates at 2^WW-1 and does not roll over. stall_cnt=1.
  - count_in==prev: stall_cnt++ (saturating at STALL_MAX). When stall_cnt reaches STALL_MAX, set stall_err and go to FAULT.
  - count_in==0 and up_reset=1: legal. No wrap, no error. stall_cnt=1.
  - Any other value: set skip_err, go to FAULT.
  - In every TRACK case, prev=count_in.
- FAULT:
  - Flags hold, wrap_count frozen, wrap_pulse=0.
  - prev keeps updating on valid samples.
  - Exits only on clr or reset.
- count_valid=0: no state, prev, stall_cnt or counter change. wrap_pulse=0.
- clr=1:
  - Next edge: skip_err=0, stall_err=0, wrap_count=0, wrap_pulse=0, FSM=INIT.
  - clr has priority over a coincident valid sample; that sample is discarded.
- tracking=1 only in TRACK.
- Simultaneous wrap and saturation: wrap_pulse still fires, wrap_count stays at max.
- up_reset with a nonzero count_in is not excused. The normal rules apply.

Optional Feature:
- Macro: COUNT_SEQ_MON_CAPTURE_EN.
- Defined:
  - Adds outputs cap_exp[CW-1:0] and cap_obs[CW-1:0], reset to 0.
  - On the cycle skip_err is first set, these latch exp and count_in.
  - They hold until clr or reset; clr clears them to 0.
- Undefined: neither port exists. No capture logic.

Test Plan:
- Reset, then valid samples 0..7,0..7,0 -> wrap_pulse high exactly 2 cycles (after each 7->0), wrap_count=2, no flags, tracking=1.
- Sequence 3,4,6 -> skip_err=1 on the cycle after the 6 sample, tracking=0. With COUNT_SEQ_MON_CAPTURE_EN: cap_exp=5, cap_obs=6.
- Sequence 2,2,2,2 with STALL_MAX=4 -> stall_err=1 after the 4th sample. Sequence 2,2,2,3 -> no flag.
- Sequence 5,6, then 0 with up_reset=1, then 1,2 -> no flags, no wrap_pulse. Same sequence with up_reset=0 -> skip_err=1.
- WW=2: 5 wraps -> wrap_count=3 (saturated), wrap_pulse still 5 times. Then clr with a coincident valid sample -> wrap_count=0, FSM=INIT, that sample ignored.
- Assert reset mid-sequence between edges -> outputs 0 immediately. After release, the first sample (e.g. 6) is accepted without a flag.
